// File: rtl/jsv_pio_pkg.sv
// Shared constants for the Julia-set visualizer input PIO: register map,
// edge-capture and interrupt mode encodings.
package jsv_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    // Debounce counter must be able to hold the full cycle count itself.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/jsv_pio_in_filter.sv
// Single-bit input conditioning: synchroniser, optional debounce filter,
// and one-cycle rise/fall strobes derived from the filtered level.
module jsv_pio_in_filter
    import jsv_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
        prev_d = filt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES > 0) begin : g_debounce
        localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0]  CNT_DONE = CW'(DEBOUNCE_CYCLES);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic [CW-1:0] cnt_inc;
        logic          filt_q;
        logic          filt_d;

        // Any cycle where the input agrees with filt restarts the stability window.
        always_comb begin
            cnt_inc = cnt_q + CW'(1);
            cnt_d   = '0;
            filt_d  = filt_q;
            if (sync_out != filt_q) begin
                if (cnt_inc == CNT_DONE) begin
                    filt_d = sync_out;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign filt = filt_q;
    end else begin : g_bypass
        assign filt = sync_out;
    end

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;

endmodule

// File: rtl/jsv_pio_in_edge.sv
// Avalon-MM input PIO: per-bit conditioned inputs, W1C edge capture,
// interrupt mask and a registered read port with single-cycle latency.
module jsv_pio_in_edge
    import jsv_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_TYPE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             unused_wdata;

    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jsv_pio_in_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .filt    (filt[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^{1'b0, writedata};

    // A clear and a new event on the same bit leave the bit set, so no edge is lost.
    always_comb begin
        wr_en = chipselect & ~write_n;

        edge_evt = rise | fall;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_evt = rise;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_evt = fall;
        end

        edgecap_d = edgecap_q;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            edgecap_d = edgecap_q & ~wdata;
        end
        edgecap_d = edgecap_d | edge_evt;

        irqmask_d = irqmask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = wdata;
        end

        irq_d = (IRQ_TYPE == IRQ_LEVEL) ? |(filt & irqmask_q) : |(edgecap_q & irqmask_q);

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = filt;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_jsv_pio_in_edge.sv
// Scoreboard bench for jsv_pio_in_edge: three configurations share one bus and
// pin stimulus; a history-window reference model predicts every output cycle.
module tb_jsv_pio_in_edge;
    import jsv_pio_pkg::*;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  pins;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int n_total = 0;
    int n_bad   = 0;
    bit running = 1'b0;

    always #5 clk = ~clk;

    jsv_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                      .EDGE_TYPE(EDGE_RISE), .IRQ_TYPE(IRQ_EDGE)) u_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(pins), .irq(irq_a));

    jsv_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4),
                      .EDGE_TYPE(EDGE_ANY), .IRQ_TYPE(IRQ_LEVEL)) u_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .in_port(pins), .irq(irq_b));

    jsv_pio_in_edge #(.WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                      .EDGE_TYPE(EDGE_FALL), .IRQ_TYPE(IRQ_EDGE)) u_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_c),
        .in_port(pins[4:0]), .irq(irq_c));

    int cfg_w   [NDUT] = '{8, 8, 5};
    int cfg_s   [NDUT] = '{2, 3, 2};
    int cfg_n   [NDUT] = '{0, 4, 4};
    int cfg_edg [NDUT] = '{EDGE_RISE, EDGE_ANY, EDGE_FALL};
    int cfg_irq [NDUT] = '{IRQ_EDGE, IRQ_LEVEL, IRQ_EDGE};

    // hist[0] is the pin value captured at the most recent edge.
    logic [7:0]  hist   [16];
    logic [31:0] m_filt [NDUT];
    logic [31:0] m_prev [NDUT];
    logic [31:0] m_edge [NDUT];
    logic [31:0] m_mask [NDUT];
    logic [31:0] m_rd   [NDUT];
    logic        m_irq  [NDUT];

    typedef struct packed {
        logic [31:0] rd_a;
        logic [31:0] rd_b;
        logic [31:0] rd_c;
        logic        irq_a;
        logic        irq_b;
        logic        irq_c;
    } exp_t;

    exp_t exp_q[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int j = 0; j < 16; j++) hist[j] = '0;
        for (int i = 0; i < NDUT; i++) begin
            m_filt[i] = '0; m_prev[i] = '0; m_edge[i] = '0;
            m_mask[i] = '0; m_rd[i]   = '0; m_irq[i]  = 1'b0;
        end
    endtask

    // Advances the model across one clock edge with the given inputs present.
    task automatic modelEdge(input logic [7:0] p, input logic [1:0] addr, input logic cs,
                             input logic wn, input logic [31:0] wd);
        logic [31:0] wmask, f0, p0, evt, flip;
        logic [31:0] nf [NDUT];
        bit          wr;
        wr = cs && !wn;
        for (int i = 0; i < NDUT; i++) begin
            wmask = (32'h1 << cfg_w[i]) - 32'h1;
            f0 = m_filt[i];
            p0 = m_prev[i];
            case (cfg_edg[i])
                EDGE_RISE: evt = f0 & ~p0;
                EDGE_FALL: evt = ~f0 & p0;
                default:   evt = f0 ^ p0;
            endcase
            case (addr)
                ADDR_DATA:    m_rd[i] = f0;
                ADDR_IRQMASK: m_rd[i] = m_mask[i];
                ADDR_EDGECAP: m_rd[i] = m_edge[i];
                default:      m_rd[i] = '0;
            endcase
            m_irq[i] = (cfg_irq[i] == IRQ_LEVEL) ? |(f0 & m_mask[i]) : |(m_edge[i] & m_mask[i]);
            if (wr && addr == ADDR_EDGECAP) m_edge[i] = m_edge[i] & ~wd;
            m_edge[i] = (m_edge[i] | evt) & wmask;
            if (wr && addr == ADDR_IRQMASK) m_mask[i] = wd & wmask;
            m_prev[i] = f0;
            // A bit flips once its last N synchronised samples all disagreed with it.
            flip = '1;
            for (int j = 0; j < cfg_n[i]; j++) flip &= (32'(hist[cfg_s[i] - 1 + j]) ^ f0);
            nf[i] = (f0 ^ flip) & wmask;
        end
        for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = p;
        for (int i = 0; i < NDUT; i++) begin
            if (cfg_n[i] == 0) m_filt[i] = 32'(hist[cfg_s[i] - 1]) & ((32'h1 << cfg_w[i]) - 32'h1);
            else               m_filt[i] = nf[i];
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e.rd_a = m_rd[0]; e.rd_b = m_rd[1]; e.rd_c = m_rd[2];
        e.irq_a = m_irq[0]; e.irq_b = m_irq[1]; e.irq_c = m_irq[2];
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge; drives one cycle of inputs and returns 1 time unit after the next edge.
    task automatic applyStimulus(input logic [7:0] p, input logic [1:0] addr, input logic cs,
                                 input logic wn, input logic [31:0] wd);
        pins = p; address = addr; chipselect = cs; write_n = wn; writedata = wd;
        if (!reset_n) modelReset();
        else          modelEdge(p, addr, cs, wn, wd);
        pushExpected();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [7:0] p, input int cycles);
        reset_n = 1'b0;
        exp_q.delete();
        modelReset();
        pushExpected();
        #1;
        checkOutput("rst_now_rd_a", rd_a, 32'h0);
        checkOutput("rst_now_rd_b", rd_b, 32'h0);
        checkOutput("rst_now_rd_c", rd_c, 32'h0);
        checkOutput("rst_now_irq", {29'b0, irq_a, irq_b, irq_c}, 32'h0);
        repeat (cycles) applyStimulus(p, ADDR_DATA, 1'b0, 1'b1, 32'h0);
        reset_n = 1'b1;
    endtask

    task automatic idle(input logic [7:0] p, input logic [1:0] addr, input int cycles);
        repeat (cycles) applyStimulus(p, addr, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic busWrite(input logic [7:0] p, input logic [1:0] addr, input logic [31:0] wd);
        applyStimulus(p, addr, 1'b1, 1'b0, wd);
    endtask

    always @(negedge clk) begin
        if (running) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("[TB] FAIL scoreboard_empty at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_rd_a", rd_a, e.rd_a);
                checkOutput("sb_rd_b", rd_b, e.rd_b);
                checkOutput("sb_rd_c", rd_c, e.rd_c);
                checkOutput("sb_irq_a", {31'b0, irq_a}, {31'b0, e.irq_a});
                checkOutput("sb_irq_b", {31'b0, irq_b}, {31'b0, e.irq_b});
                checkOutput("sb_irq_c", {31'b0, irq_c}, {31'b0, e.irq_c});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  rp;
        logic [1:0]  ra;
        logic        rcs, rwn;
        logic [31:0] rwd;
        int          r;

        reset_n = 1'b0; pins = 8'hA5; address = '0; chipselect = 1'b0;
        write_n = 1'b1; writedata = '0;
        modelReset();
        @(posedge clk);
        #1;
        running = 1'b1;

        $display("[TB] reset with pins held at A5");
        doReset(8'hA5, 3);
        idle(8'hA5, ADDR_DATA, 12);
        checkOutput("rst_data_a", rd_a, 32'hA5);
        checkOutput("rst_data_b", rd_b, 32'hA5);
        checkOutput("rst_data_c", rd_c, 32'h05);
        idle(8'hA5, ADDR_EDGECAP, 1);
        checkOutput("rst_edge_a", rd_a, 32'hA5);
        checkOutput("rst_edge_b", rd_b, 32'hA5);
        checkOutput("rst_edge_c", rd_c, 32'h00);

        $display("[TB] edge capture and write-1-to-clear on bit3");
        idle(8'h00, ADDR_DATA, 12);
        busWrite(8'h00, ADDR_EDGECAP, 32'hFF);
        idle(8'h00, ADDR_EDGECAP, 1);
        checkOutput("clr_all_a", rd_a, 32'h0);
        checkOutput("clr_all_c", rd_c, 32'h0);
        idle(8'h08, ADDR_EDGECAP, 12);
        checkOutput("b3_rise_a", rd_a, 32'h08);
        checkOutput("b3_rise_b", rd_b, 32'h08);
        checkOutput("b3_rise_c", rd_c, 32'h00);
        idle(8'h00, ADDR_EDGECAP, 12);
        checkOutput("b3_fall_a", rd_a, 32'h08);
        checkOutput("b3_fall_b", rd_b, 32'h08);
        checkOutput("b3_fall_c", rd_c, 32'h08);
        busWrite(8'h00, ADDR_EDGECAP, 32'h8);
        idle(8'h00, ADDR_EDGECAP, 1);
        checkOutput("b3_w1c_a", rd_a, 32'h0);
        checkOutput("b3_w1c_b", rd_b, 32'h0);
        checkOutput("b3_w1c_c", rd_c, 32'h0);

        $display("[TB] event and clear on the same edge");
        idle(8'h01, ADDR_DATA, 2);
        busWrite(8'h01, ADDR_EDGECAP, 32'h1);
        idle(8'h01, ADDR_EDGECAP, 1);
        checkOutput("set_wins_a", rd_a, 32'h1);

        $display("[TB] debounce: short glitch then long pulse on bit1");
        idle(8'h00, ADDR_DATA, 12);
        busWrite(8'h00, ADDR_EDGECAP, 32'hFF);
        idle(8'h02, ADDR_DATA, 3);
        idle(8'h00, ADDR_EDGECAP, 12);
        checkOutput("glitch_a", rd_a, 32'h02);
        checkOutput("glitch_b", rd_b, 32'h00);
        checkOutput("glitch_c", rd_c, 32'h00);
        busWrite(8'h00, ADDR_EDGECAP, 32'hFF);
        idle(8'h02, ADDR_DATA, 6);
        idle(8'h00, ADDR_EDGECAP, 12);
        checkOutput("pulse_b", rd_b, 32'h02);
        checkOutput("pulse_c", rd_c, 32'h02);

        $display("[TB] edge interrupt on bit4");
        busWrite(8'h00, ADDR_EDGECAP, 32'hFF);
        busWrite(8'h00, ADDR_IRQMASK, 32'h10);
        idle(8'h10, ADDR_IRQMASK, 8);
        checkOutput("irq_edge_a", {31'b0, irq_a}, 32'h1);
        checkOutput("mask_read_a", rd_a, 32'h10);
        busWrite(8'h10, ADDR_EDGECAP, 32'h10);
        idle(8'h10, ADDR_DATA, 1);
        checkOutput("irq_clr_a", {31'b0, irq_a}, 32'h0);
        idle(8'h30, ADDR_DATA, 10);
        checkOutput("irq_masked_a", {31'b0, irq_a}, 32'h0);
        checkOutput("irq_level_b4", {31'b0, irq_b}, 32'h1);

        $display("[TB] level interrupt on bit0 and reset while debouncing");
        busWrite(8'h00, ADDR_IRQMASK, 32'h01);
        idle(8'h01, ADDR_DATA, 12);
        checkOutput("irq_level_hi_b", {31'b0, irq_b}, 32'h1);
        idle(8'h00, ADDR_DATA, 12);
        checkOutput("irq_level_lo_b", {31'b0, irq_b}, 32'h0);
        idle(8'h02, ADDR_DATA, 2);
        doReset(8'h00, 2);
        idle(8'h00, ADDR_EDGECAP, 12);
        checkOutput("post_rst_edge_a", rd_a, 32'h0);
        checkOutput("post_rst_edge_b", rd_b, 32'h0);
        checkOutput("post_rst_edge_c", rd_c, 32'h0);
        idle(8'h00, ADDR_IRQMASK, 1);
        checkOutput("post_rst_mask_b", rd_b, 32'h0);

        $display("[TB] randomized traffic");
        rp = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) doReset(rp, 2);
            if ($urandom_range(0, 3) == 0) rp = rp ^ 8'(1 << $urandom_range(0, 7));
            r   = $urandom_range(0, 99);
            ra  = 2'($urandom_range(0, 3));
            rcs = 1'b1;
            rwn = 1'b1;
            rwd = $urandom;
            if (r < 10) begin
                ra = ADDR_IRQMASK; rwn = 1'b0;
            end else if (r < 25) begin
                ra = ADDR_EDGECAP; rwn = 1'b0;
            end else if (r < 30) begin
                ra = 2'($urandom_range(0, 1)); rwn = 1'b0;
            end else if (r < 35) begin
                rcs = 1'b0; rwn = 1'b0;
            end
            applyStimulus(rp, ra, rcs, rwn, rwd);
        end

        @(negedge clk);
        #1;
        running = 1'b0;
        checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
